// File: rtl/mmio_io_controller.sv
// Memory-mapped I/O: 7-seg/LED outputs, debounced keys/switches, sticky key capture with W1C and irq.
// Latency: writes take effect at the hit edge; read data and rd_valid appear one cycle after rd_en.
// Backpressure: none; every hit access is accepted in a single cycle with no stall.
//
// Ports: clk/reset (async active-low); bus addr/wr_en/wr_data/rd_en -> rd_data/rd_valid, hit (comb decode);
//        KEY (active-low raw), SW (raw) in; LEDR, HEX (active-low segments), irq (registered level) out.
module mmio_io_controller #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_BASE       = 32'hF000_0000,
    parameter int               HEX_DIGITS      = 4,
    parameter int               LED_WIDTH       = 10,
    parameter int               SW_WIDTH        = 10,
    parameter int               KEY_WIDTH       = 4,
    parameter int               DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DBITS-1:0]        addr,
    input  logic                    wr_en,
    input  logic [DBITS-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [DBITS-1:0]        rd_data,
    output logic                    rd_valid,
    output logic                    hit,
    input  logic [KEY_WIDTH-1:0]    KEY,
    input  logic [SW_WIDTH-1:0]     SW,
    output logic [LED_WIDTH-1:0]    LEDR,
    output logic [7*HEX_DIGITS-1:0] HEX,
    output logic                    irq
);
    localparam int HEXW = 4 * HEX_DIGITS;
    localparam int NB   = KEY_WIDTH + SW_WIDTH;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] OFF_HEX  = 3'd0;
    localparam logic [2:0] OFF_LED  = 3'd1;
    localparam logic [2:0] OFF_KEY  = 3'd4;
    localparam logic [2:0] OFF_SW   = 3'd5;
    localparam logic [2:0] OFF_STAT = 3'd6;
    localparam logic [2:0] OFF_IE   = 3'd7;

    logic [HEXW-1:0]      hex_reg;
    logic [KEY_WIDTH-1:0] press, ovr, key_ie;
    logic [KEY_WIDTH-1:0] press_nxt, ovr_nxt, key_rise, clr_press, clr_ovr;
    logic [NB-1:0]        raw, sync1, sync2, stable, stable_nxt;
    logic [CW-1:0]        cnt     [NB];
    logic [CW-1:0]        cnt_nxt [NB];
    logic [2:0]           off;
    logic                 wr_hit;
    logic [DBITS-1:0]     rd_mux;
    logic                 unused_bits;

    assign unused_bits = ^{addr[1:0], wr_data};

    assign hit    = (addr[DBITS-1:5] == ADDR_BASE[DBITS-1:5]);
    assign off    = addr[4:2];
    assign wr_hit = wr_en & hit;

    // Keys are inverted on entry so every internal bit is 1 = asserted.
    assign raw = {SW, ~KEY};

    // Debounce: a differing synchronised level must persist DEBOUNCE_CYCLES edges before it is accepted.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            stable_nxt[i] = stable[i];
            cnt_nxt[i]    = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Press is judged on the accepting edge itself, so capture lines up with the stable update.
    assign key_rise  = stable_nxt[KEY_WIDTH-1:0] & ~stable[KEY_WIDTH-1:0];
    assign clr_press = (wr_hit && off == OFF_STAT) ? wr_data[KEY_WIDTH-1:0]  : '0;
    assign clr_ovr   = (wr_hit && off == OFF_STAT) ? wr_data[16 +: KEY_WIDTH] : '0;
    // A press landing on a cleared bit counts as a fresh capture, not an overrun.
    assign press_nxt = key_rise | (press & ~clr_press);
    assign ovr_nxt   = (key_rise & press & ~clr_press) | (ovr & ~clr_ovr);

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_HEX:  rd_mux[HEXW-1:0]      = hex_reg;
            OFF_LED:  rd_mux[LED_WIDTH-1:0] = LEDR;
            OFF_KEY:  rd_mux[KEY_WIDTH-1:0] = stable[KEY_WIDTH-1:0];
            OFF_SW:   rd_mux[SW_WIDTH-1:0]  = stable[NB-1:KEY_WIDTH];
            OFF_STAT: begin
                rd_mux[KEY_WIDTH-1:0]  = press;
                rd_mux[16 +: KEY_WIDTH] = ovr;
            end
            OFF_IE:   rd_mux[KEY_WIDTH-1:0] = key_ie;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_reg  <= '0;
            LEDR     <= '0;
            key_ie   <= '0;
            press    <= '0;
            ovr      <= '0;
            irq      <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            stable <= stable_nxt;
            for (int i = 0; i < NB; i++) cnt[i] <= cnt_nxt[i];
            press <= press_nxt;
            ovr   <= ovr_nxt;
            // Built from current state, so irq trails key_stat/key_ie by one cycle.
            irq   <= |(press & key_ie);
            if (wr_hit) begin
                case (off)
                    OFF_HEX: hex_reg <= wr_data[HEXW-1:0];
                    OFF_LED: LEDR    <= wr_data[LED_WIDTH-1:0];
                    OFF_IE:  key_ie  <= wr_data[KEY_WIDTH-1:0];
                    default: ;
                endcase
            end
            // rd_mux sees pre-write state, so a same-cycle write does not leak into the read.
            rd_valid <= rd_en & hit;
            if (rd_en && hit) rd_data <= rd_mux;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    for (genvar g = 0; g < HEX_DIGITS; g++) begin : g_hex
        assign HEX[7*g +: 7] = seg7(hex_reg[4*g +: 4]);
    end
endmodule

// File: tb/tb_mmio_io_controller.sv
module tb_mmio_io_controller;
    localparam logic [31:0] BASE = 32'hF000_0000;
    localparam int DEB = 16;
    localparam int NB  = 14;

    logic        clk, reset, wr_en, rd_en, rd_valid, hit, irq;
    logic [31:0] addr, wr_data, rd_data;
    logic [3:0]  KEY;
    logic [9:0]  SW, LEDR;
    logic [27:0] HEX;

    mmio_io_controller #(
        .DBITS(32), .ADDR_BASE(BASE), .HEX_DIGITS(4), .LED_WIDTH(10),
        .SW_WIDTH(10), .KEY_WIDTH(4), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .hit(hit),
        .KEY(KEY), .SW(SW), .LEDR(LEDR), .HEX(HEX), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0]   m_hex;
    logic [9:0]    m_led;
    logic [3:0]    m_press, m_ovr, m_ie, m_rise, m_cp, m_co;
    logic          m_irq, m_irq_nx, m_rd_valid, m_we, m_re, same;
    logic [31:0]   m_rd_data;
    logic [2:0]    m_off;
    logic [NB-1:0] m_stable, m_new_st;
    logic [NB-1:0] hist [0:DEB];   // hist[0] = newest raw sample (1 = asserted)

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'h1F);
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: seg = 7'b1000000; 4'h1: seg = 7'b1111001; 4'h2: seg = 7'b0100100; 4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001; 4'h5: seg = 7'b0010010; 4'h6: seg = 7'b0000010; 4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000; 4'h9: seg = 7'b0010000; 4'hA: seg = 7'b0001000; 4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110; 4'hD: seg = 7'b0100001; 4'hE: seg = 7'b0000110; default: seg = 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] exp_hex(input logic [15:0] h);
        logic [27:0] r;
        for (int d = 0; d < 4; d++) r[7*d +: 7] = seg(h[4*d +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] mread(input logic [2:0] o);
        case (o)
            3'd0: return {16'h0, m_hex};
            3'd1: return {22'h0, m_led};
            3'd4: return {28'h0, m_stable[3:0]};
            3'd5: return {22'h0, m_stable[13:4]};
            3'd6: return {12'h0, m_ovr, 12'h0, m_press};
            3'd7: return {28'h0, m_ie};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hex = '0; m_led = '0; m_press = '0; m_ovr = '0; m_ie = '0; m_irq = 0;
            m_rd_data = '0; m_rd_valid = 0; m_stable = '0;
            for (int k = 0; k <= DEB; k++) hist[k] = '0;
        end else begin
            m_off = addr[4:2];
            m_we  = wr_en && in_range(addr);
            m_re  = rd_en && in_range(addr);
            m_rd_valid = m_re;
            if (m_re) m_rd_data = mread(m_off);
            m_irq_nx = |(m_press & m_ie);
            // A level is accepted once the last DEB synchronised samples (2 cycles old) all agree on it.
            m_new_st = m_stable;
            for (int b = 0; b < NB; b++) begin
                same = 1;
                for (int k = 2; k <= DEB; k++) if (hist[k][b] !== hist[1][b]) same = 0;
                if (same && hist[1][b] !== m_stable[b]) m_new_st[b] = hist[1][b];
            end
            m_rise   = m_new_st[3:0] & ~m_stable[3:0];
            m_stable = m_new_st;
            for (int k = DEB; k >= 1; k--) hist[k] = hist[k-1];
            hist[0] = {SW, ~KEY};
            m_cp = (m_we && m_off == 3'd6) ? wr_data[3:0]   : 4'h0;
            m_co = (m_we && m_off == 3'd6) ? wr_data[19:16] : 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (m_rise[i]) begin
                    if (m_press[i] && !m_cp[i]) m_ovr[i] = 1'b1;
                    else if (m_co[i])           m_ovr[i] = 1'b0;
                    m_press[i] = 1'b1;
                end else begin
                    if (m_cp[i]) m_press[i] = 1'b0;
                    if (m_co[i]) m_ovr[i]   = 1'b0;
                end
            end
            if (m_we && m_off == 3'd0) m_hex = wr_data[15:0];
            if (m_we && m_off == 3'd1) m_led = wr_data[9:0];
            if (m_we && m_off == 3'd7) m_ie  = wr_data[3:0];
            m_irq = m_irq_nx;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("hit",      {31'h0, hit},      {31'h0, in_range(addr)});
            check("rd_valid", {31'h0, rd_valid}, {31'h0, m_rd_valid});
            check("rd_data",  rd_data,           m_rd_data);
            check("ledr",     {22'h0, LEDR},     {22'h0, m_led});
            check("hex",      {4'h0, HEX},       {4'h0, exp_hex(m_hex)});
            check("irq",      {31'h0, irq},      {31'h0, m_irq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic [31:0] a, input logic we, input logic re, input logic [31:0] d);
        addr = a; wr_en = we; rd_en = re; wr_data = d;
        cyc();
        wr_en = 0; rd_en = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
        bus(a, 0, 1, 32'h0);
        d = rd_data;
        v = rd_valid;
    endtask

    logic [31:0] d;
    logic        v;

    initial begin
        reset = 0; addr = BASE; wr_en = 0; rd_en = 0; wr_data = 0; KEY = 4'hF; SW = '0;
        repeat (3) cyc();
        chk_on = 1;
        // 1: reset state
        check("rst_ledr", {22'h0, LEDR}, 32'h0);
        check("rst_hex",  {4'h0, HEX},   {4'h0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000});
        check("rst_irq",  {31'h0, irq},  32'h0);
        reset = 1;
        cyc();
        rd(BASE + 32'h18, d, v);
        check("rst_stat", d, 32'h0);
        check("rst_stat_v", {31'h0, v}, 32'h1);
        // 2: hex / led write and readback
        bus(BASE, 1, 0, 32'h0000_BEEF);
        bus(BASE + 32'h4, 1, 0, 32'h3FF);
        check("hex_beef", {4'h0, HEX}, {4'h0, 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110});
        check("ledr_3ff", {22'h0, LEDR}, 32'h3FF);
        rd(BASE, d, v);
        check("rd_hex", d, 32'h0000_BEEF);
        check("rd_hex_v", {31'h0, v}, 32'h1);
        rd(BASE + 32'h4, d, v);
        check("rd_led", d, 32'h3FF);
        cyc();
        check("rd_v_drop", {31'h0, rd_valid}, 32'h0);
        check("rd_hold", rd_data, 32'h3FF);
        // 3: glitch then debounce
        KEY[1] = 0; repeat (15) cyc(); KEY[1] = 1;
        repeat (25) cyc();
        rd(BASE + 32'h10, d, v);
        check("glitch", d, 32'h0);
        KEY[1] = 0; repeat (18) cyc();
        rd(BASE + 32'h10, d, v);
        check("deb_key", d, 32'h2);
        rd(BASE + 32'h18, d, v);
        check("deb_stat", d, 32'h2);
        // 4: irq, overrun, W1C
        bus(BASE + 32'h1C, 1, 0, 32'h2);
        check("irq_lag", {31'h0, irq}, 32'h0);
        cyc();
        check("irq_set", {31'h0, irq}, 32'h1);
        KEY[1] = 1; repeat (20) cyc();
        KEY[1] = 0; repeat (20) cyc();
        rd(BASE + 32'h18, d, v);
        check("ovr", d, 32'h0002_0002);
        bus(BASE + 32'h18, 1, 0, 32'h0002_0002);
        rd(BASE + 32'h18, d, v);
        check("w1c", d, 32'h0);
        check("irq_clr", {31'h0, irq}, 32'h0);
        // 5: press of KEY[0] lands on the same edge as its clear
        KEY[0] = 0; repeat (20) cyc(); KEY[0] = 1; repeat (20) cyc();
        KEY[0] = 0; repeat (17) cyc();
        bus(BASE + 32'h18, 1, 0, 32'h1);
        rd(BASE + 32'h18, d, v);
        check("set_wins", d, 32'h1);
        // 6: decode and reset mid-debounce
        KEY = 4'hF; repeat (20) cyc();
        addr = BASE + 32'h20; rd_en = 1;
        #1 check("miss_hit", {31'h0, hit}, 32'h0);
        cyc(); rd_en = 0;
        check("miss_v", {31'h0, rd_valid}, 32'h0);
        rd(BASE + 32'h8, d, v);
        check("unmap_v", {31'h0, v}, 32'h1);
        check("unmap_d", d, 32'h0);
        KEY[2] = 0; repeat (10) cyc();
        reset = 0; cyc(); cyc(); reset = 1;
        check("rst2_ledr", {22'h0, LEDR}, 32'h0);
        repeat (12) cyc();
        rd(BASE + 32'h10, d, v);
        check("rst_deb", d, 32'h0);
        repeat (10) cyc();
        rd(BASE + 32'h10, d, v);
        check("rst_deb2", d, 32'h4);
        // randomized traffic against the model
        for (int it = 0; it < 700; it++) begin
            case ($urandom_range(0, 9))
                0, 1: begin KEY[$urandom_range(0, 3)] ^= 1'b1; cyc(); end
                2:    begin SW[$urandom_range(0, 9)] ^= 1'b1; cyc(); end
                3:    bus(BASE + 4 * $urandom_range(0, 7), 1, 0, $urandom);
                4:    bus(BASE + 4 * $urandom_range(0, 7), 0, 1, 0);
                5:    bus(BASE + 4 * $urandom_range(0, 7), 1, 1, $urandom);
                6:    bus(BASE + 32'h18, 1, $urandom_range(0, 1), $urandom);
                7:    bus(BASE - 32'h20 + $urandom_range(0, 95), $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
                default: repeat ($urandom_range(1, 30)) cyc();
            endcase
        end
        repeat (5) cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
